checked_consumer: RTL and testbench
===================================

CHECKED_CONSUMER -- requirements
Module: checked_consumer

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- consumer_id, 0, identifier of this sink within the bench.
- data_width, 32, width of the data bus.
- max_data_size, 5000, number of tokens to accept before finishing.
- initial_value, 0, first value the upstream producer sends.
- exp_mul, 3, multiplier applied by the expected-value model.
- exp_add, 2, addend applied by the expected-value model.
- watchdog_cycles, 1024, watchdog limit (only meaningful when the Configuration macro is defined).
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  out  1  token request to the upstream out stage.
- ack  in  1  one-cycle pulse from upstream; din is valid in the same cycle.
- din  in  data_width  token data.
- count  out  32  number of tokens accepted.
- err_count  out  16  number of value mismatches.
- first_err_idx  out  32  count value at the first mismatch.
- cycles  out  32  clocks spent in RUN.
- stall_cycles  out  32  RUN clocks with req=1 and ack=0.
- done  out  1  high once max_data_size tokens are accepted.
- overrun  out  1  sticky; set by an ack outside RUN.
- timeout  out  1  sticky; set by the watchdog.

Function
REQ-003 The FSM SHALL have states IDLE, RUN, DONE and, only when the macro is defined, TIMEOUT.
- IDLE->RUN on the first clock after reset is released.
- RUN->DONE on the clock that accepts token number max_data_size.
REQ-004 req SHALL be 1 in every RUN cycle and 0 in IDLE, DONE and TIMEOUT.
REQ-005 A token SHALL be accepted on any clock in RUN where ack=1; acceptance does not depend on the current req value.
REQ-006 On each acceptance the block SHALL compare din with the expected value.
- Expected value = exp_mul*(initial_value+count)+exp_add, truncated to data_width bits.
- Wrap-around modulo 2^data_width is legal and is not an error.
REQ-007 On a mismatch err_count SHALL increment, saturating at 16'hFFFF.
- first_err_idx is loaded with the current count only when err_count was 0.
REQ-008 count SHALL increment on every acceptance, whether or not the value matched.
REQ-009 cycles SHALL increment on every RUN clock; stall_cycles SHALL increment on every RUN clock with ack=0.
REQ-010 done SHALL be registered and SHALL be 1 in the clock after the final acceptance; DONE SHALL be terminal until reset.
REQ-011 An ack in IDLE, DONE or TIMEOUT SHALL set overrun and SHALL change no counter.
REQ-012 If max_data_size is 0, the block SHALL go IDLE->DONE and never assert req.

Reset
REQ-013 When rst=1 at a clock edge, the block SHALL enter IDLE and clear every output to 0, including the sticky flags.
REQ-014 A reset asserted mid-RUN SHALL abandon the run; any ack sampled during reset SHALL be ignored.

Configuration
REQ-015 Macro CHECKED_CONSUMER_WATCHDOG_EN SHALL control the watchdog.
- Defined: a counter clears on each acceptance and counts RUN clocks without ack.
- Defined: on reaching watchdog_cycles the FSM enters TIMEOUT and sets timeout; TIMEOUT is terminal until reset.
- Undefined: no counter and no TIMEOUT state; timeout is tied to 0.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Upstream sends 0,1,2,… mapped to 3x+2 (2,5,8,…); max_data_size=8, one ack every 4 clocks -> count=8, err_count=0, done=1, cycles≈32, stall_cycles=24.
- Token 3 replaced by 0 -> err_count=1, first_err_idx=3, count still increments to max.
- data_width=8, initial_value=84 -> expected 254, then 1 (wrap); both count as matches, err_count=0.
- Extra ack pulse 2 clocks after done -> overrun=1, count unchanged.
- rst pulsed after 3 acceptances -> all outputs 0; the next run restarts from expected value exp_add.
- With CHECKED_CONSUMER_WATCHDOG_EN and watchdog_cycles=16, no ack is sent -> timeout=1 and req=0 at RUN clock 16; without the macro, timeout stays 0.

Source files
------------

// File: rtl/checked_consumer.sv
// checked_consumer
//   Token sink for a req/ack stream. Each token it accepts is compared with
//   the value the upstream producer should have sent:
//     exp_mul*(initial_value+count)+exp_add, truncated to data_width bits.
//   The block keeps counts of tokens, mismatches and RUN/stall clocks. It
//   flags acks that arrive outside RUN, and it can time out an idle stream.
//
// Optional feature: define CHECKED_CONSUMER_WATCHDOG_EN to enable the
//   watchdog and the TIMEOUT state. Without it, timeout is tied to 0.
//
// Ports
//   clk            single clock; all logic on its rising edge
//   rst            synchronous, active-high reset
//   req            token request to upstream (1 in every RUN cycle)
//   ack            one-cycle pulse from upstream; din is valid in that cycle
//   din            token data
//   count          number of tokens accepted
//   err_count      number of value mismatches (saturates)
//   first_err_idx  count value at the first mismatch
//   cycles         clocks spent in RUN
//   stall_cycles   RUN clocks with no ack
//   done           high once max_data_size tokens are accepted
//   overrun        sticky; set by an ack outside RUN
//   timeout        sticky; set by the watchdog
//
// State    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | after reset; leaves on the first clock with rst low
// S_RUN    | requesting and accepting tokens
// S_DONE   | max_data_size tokens accepted; terminal until reset
// S_TIMEOUT| watchdog expired (watchdog builds only); terminal until reset

module checked_consumer #(
  parameter int consumer_id     = 0,
  parameter int data_width      = 32,
  parameter int max_data_size   = 5000,
  parameter int initial_value   = 0,
  parameter int exp_mul         = 3,
  parameter int exp_add         = 2,
  parameter int watchdog_cycles = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req,
  input  logic                  ack,
  input  logic [data_width-1:0] din,
  output logic [31:0]           count,
  output logic [15:0]           err_count,
  output logic [31:0]           first_err_idx,
  output logic [31:0]           cycles,
  output logic [31:0]           stall_cycles,
  output logic                  done,
  output logic                  overrun,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
`ifdef CHECKED_CONSUMER_WATCHDOG_EN
    , S_TIMEOUT
`endif
  } state_t;

  state_t state;

  // The last token is the one accepted while count holds max_data_size-1.
  localparam logic [31:0] LAST_IDX = 32'(max_data_size - 1);

  // Expected value, computed entirely in data_width bits so that
  // wrap-around is the natural modulo result.
  logic [data_width-1:0] exp_base;
  logic [data_width-1:0] exp_val;

  always_comb begin
    exp_base = data_width'(initial_value) + data_width'(count);
    exp_val  = exp_base * data_width'(exp_mul) + data_width'(exp_add);
  end

`ifdef CHECKED_CONSUMER_WATCHDOG_EN
  // Down-counter of ack-less RUN clocks left before timing out.
  localparam logic [31:0] WD_LOAD = 32'(watchdog_cycles);
  logic [31:0] wd_left;

  logic unused_cfg;
  assign unused_cfg = ^{32'(consumer_id)};
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(consumer_id), 32'(watchdog_cycles)};
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      req           <= 1'b0;
      count         <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      cycles        <= '0;
      stall_cycles  <= '0;
      done          <= 1'b0;
      overrun       <= 1'b0;
`ifdef CHECKED_CONSUMER_WATCHDOG_EN
      timeout       <= 1'b0;
      wd_left       <= WD_LOAD;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ack) overrun <= 1'b1;
          if (max_data_size == 0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_RUN;
            req   <= 1'b1;
`ifdef CHECKED_CONSUMER_WATCHDOG_EN
            wd_left <= WD_LOAD;
`endif
          end
        end

        S_RUN: begin
          cycles <= cycles + 32'd1;
          if (ack) begin
            count <= count + 32'd1;
            if (din != exp_val) begin
              if (err_count == 16'd0) first_err_idx <= count;
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
`ifdef CHECKED_CONSUMER_WATCHDOG_EN
            wd_left <= WD_LOAD;
`endif
            if (count == LAST_IDX) begin
              state <= S_DONE;
              req   <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            stall_cycles <= stall_cycles + 32'd1;
`ifdef CHECKED_CONSUMER_WATCHDOG_EN
            // <= 1 also catches a watchdog_cycles of 0 on the first idle clock.
            if (wd_left <= 32'd1) begin
              state   <= S_TIMEOUT;
              req     <= 1'b0;
              timeout <= 1'b1;
            end else begin
              wd_left <= wd_left - 32'd1;
            end
`endif
          end
        end

        default: begin
          // DONE and TIMEOUT: terminal; a stray ack only raises overrun.
          if (ack) overrun <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_checked_consumer.sv
module tb_checked_consumer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance: 32-bit data, 8 tokens, watchdog limit 16
  logic        ack_m = 1'b0;
  logic [31:0] din_m = '0;
  logic        req_m, done_m, ovr_m, tmo_m;
  logic [31:0] cnt_m, fidx_m, cyc_m, stl_m;
  logic [15:0] err_m;

  // 8-bit instance starting at 84 (wrap check)
  logic        ack_w = 1'b0;
  logic [7:0]  din_w = '0;
  logic        req_w, done_w, ovr_w, tmo_w;
  logic [31:0] cnt_w, fidx_w, cyc_w, stl_w;
  logic [15:0] err_w;

  // zero-size instance
  logic        ack_z = 1'b0;
  logic [31:0] din_z = '0;
  logic        req_z, done_z, ovr_z, tmo_z;
  logic [31:0] cnt_z, fidx_z, cyc_z, stl_z;
  logic [15:0] err_z;

  checked_consumer #(.consumer_id(0), .data_width(32), .max_data_size(8),
                     .initial_value(0), .exp_mul(3), .exp_add(2),
                     .watchdog_cycles(16)) u_main (
    .clk(clk), .rst(rst), .req(req_m), .ack(ack_m), .din(din_m),
    .count(cnt_m), .err_count(err_m), .first_err_idx(fidx_m),
    .cycles(cyc_m), .stall_cycles(stl_m), .done(done_m),
    .overrun(ovr_m), .timeout(tmo_m));

  checked_consumer #(.consumer_id(1), .data_width(8), .max_data_size(2),
                     .initial_value(84), .exp_mul(3), .exp_add(2),
                     .watchdog_cycles(1024)) u_w8 (
    .clk(clk), .rst(rst), .req(req_w), .ack(ack_w), .din(din_w),
    .count(cnt_w), .err_count(err_w), .first_err_idx(fidx_w),
    .cycles(cyc_w), .stall_cycles(stl_w), .done(done_w),
    .overrun(ovr_w), .timeout(tmo_w));

  checked_consumer #(.consumer_id(2), .data_width(32), .max_data_size(0),
                     .initial_value(0), .exp_mul(3), .exp_add(2),
                     .watchdog_cycles(1024)) u_zero (
    .clk(clk), .rst(rst), .req(req_z), .ack(ack_z), .din(din_z),
    .count(cnt_z), .err_count(err_z), .first_err_idx(fidx_z),
    .cycles(cyc_z), .stall_cycles(stl_z), .done(done_z),
    .overrun(ovr_z), .timeout(tmo_z));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset clocks, then release; the next edge moves IDLE->RUN.
  task automatic do_reset();
    rst   = 1'b1;
    ack_m = 1'b0;
    ack_w = 1'b0;
    ack_z = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] v, input int gap);
    repeat (gap) tick();
    ack_m = 1'b1;
    din_m = v;
    tick();
    ack_m = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    tick();
    tick();
    chk("rst_count",   cnt_m, 0);
    chk("rst_req",     req_m, 0);
    chk("rst_done",    done_m, 0);
    chk("rst_overrun", ovr_m, 0);
    chk("rst_cycles",  cyc_m, 0);
    chk("rst_timeout", tmo_m, 0);
    rst = 1'b0;
    tick();
    chk("run_req",     req_m, 1);
    chk("zero_done",   done_z, 1);
    chk("zero_req",    req_z, 0);

    // ---- clean run: 2,5,8,... one ack every 4 clocks ----
    for (int i = 0; i < 8; i++) send_m(32'(3 * i + 2), 3);
    chk("s1_count",  cnt_m, 8);
    chk("s1_err",    err_m, 0);
    chk("s1_done",   done_m, 1);
    chk("s1_req",    req_m, 0);
    chk("s1_cycles", cyc_m, 32);
    chk("s1_stall",  stl_m, 24);
    chk("s1_fidx",   fidx_m, 0);
    chk("s1_ovr",    ovr_m, 0);

    // ---- 8-bit wrap: 254 then 1 ----
    ack_w = 1'b1;
    din_w = 8'd254;
    tick();
    din_w = 8'd1;
    tick();
    ack_w = 1'b0;
    chk("w8_count", cnt_w, 2);
    chk("w8_err",   err_w, 0);
    chk("w8_done",  done_w, 1);

    // ---- stray ack 2 clocks after done ----
    send_m(32'd26, 2);
    chk("ovr_flag",   ovr_m, 1);
    chk("ovr_count",  cnt_m, 8);
    chk("ovr_cycles", cyc_m, 32);
    chk("ovr_done",   done_m, 1);

    // ---- reset mid-run, ack held during reset ----
    do_reset();
    tick();
    send_m(32'd2, 0);
    send_m(32'd5, 0);
    send_m(32'd8, 0);
    chk("mid_count", cnt_m, 3);
    rst   = 1'b1;
    ack_m = 1'b1;
    din_m = 32'd11;
    tick();
    chk("mrst_count", cnt_m, 0);
    chk("mrst_req",   req_m, 0);
    chk("mrst_cyc",   cyc_m, 0);
    chk("mrst_ovr",   ovr_m, 0);
    chk("mrst_done",  done_m, 0);
    tick();
    rst   = 1'b0;
    ack_m = 1'b0;
    tick();
    chk("restart_count", cnt_m, 0);
    chk("restart_ovr",   ovr_m, 0);
    send_m(32'd2, 0);
    chk("restart_tok0_err", err_m, 0);
    chk("restart_tok0_cnt", cnt_m, 1);

    // ---- continue back-to-back with token 3 corrupted to 0 ----
    send_m(32'd5, 0);
    send_m(32'd8, 0);
    send_m(32'd0, 0);
    send_m(32'd14, 0);
    send_m(32'd17, 0);
    send_m(32'd20, 0);
    send_m(32'd23, 0);
    chk("err_count", err_m, 1);
    chk("err_fidx",  fidx_m, 3);
    chk("err_cnt",   cnt_m, 8);
    chk("err_done",  done_m, 1);
    chk("err_cyc",   cyc_m, 8);
    chk("err_stall", stl_m, 0);

    // ---- watchdog: no acks ----
    do_reset();
    tick();
    repeat (15) tick();
    chk("wd_pre_tmo", tmo_m, 0);
    chk("wd_pre_req", req_m, 1);
    tick();
`ifdef CHECKED_CONSUMER_WATCHDOG_EN
    chk("wd_tmo", tmo_m, 1);
    chk("wd_req", req_m, 0);
`else
    chk("wd_tmo", tmo_m, 0);
    chk("wd_req", req_m, 1);
`endif
    chk("wd_cyc",   cyc_m, 16);
    chk("wd_stall", stl_m, 16);
    chk("wd_count", cnt_m, 0);

    // zero-size sink never requested
    chk("zero_req_end",   req_z, 0);
    chk("zero_count_end", cnt_z, 0);
    chk("zero_done_end",  done_z, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
